ahb3lite_burst_master: RTL

Parametrised AHB3-Lite bus master that executes one command-driven read or write burst at a time. It handles wait states, HRESP ERROR abort and 1 KB boundary re-arbitration. It sits between the CPU register block (command port) and the AHB3-Lite interconnect, and generalises the fixed word-read master to configurable widths, lengths and both directions.

---
 rtl/ahb3lite_burst_master.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ahb3lite_burst_master.sv
// ahb3lite_burst_master: command-driven AHB3-Lite INCR/SINGLE burst master with
// wait states, ERROR abort and NONSEQ re-arbitration at every 1 KB boundary.
module ahb3lite_burst_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    input  logic [DATA_W-1:0] HRDATA
);
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, BURST, LAST, ERR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              write_q, write_d;
    logic              dp_q, dp_d;
    logic [2:0]        burst_q, burst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              data_err;
    logic              data_ok;

    // dp_q marks an outstanding data phase (the beat accepted on the previous HREADY edge)
    assign data_err  = dp_q && HRESP && !HREADY;
    assign data_ok   = dp_q && HREADY && !HRESP;
    assign cmd_ready = (state_q == IDLE) && !done_q;
    assign wr_ready  = (state_q == BURST) && write_q && HREADY;
    assign HTRANS    = (state_q != BURST) ? 2'b00 :
                       (beat_q == '0 || addr_q[9:0] == '0) ? 2'b10 : 2'b11;
    assign HADDR     = addr_q;
    assign HWRITE    = write_q;
    assign HSIZE     = (DATA_W == 64) ? 3'b011 : 3'b010;
    assign HBURST    = burst_q;
    assign HWDATA    = wdata_q;
    assign rd_data   = rdata_q;
    assign rd_valid  = rvalid_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        len_d    = len_q;
        write_d  = write_q;
        burst_d  = burst_q;
        dp_d     = HREADY ? (state_q == BURST) : dp_q;
        wdata_d  = wr_ready ? wr_data : wdata_q;
        rvalid_d = data_ok && !write_q && (state_q != ERR);
        rdata_d  = rvalid_d ? HRDATA : rdata_q;
        done_d   = (state_q == LAST && HREADY && !HRESP) || (state_q == ERR && HREADY);
        err_d    = (state_q == ERR) && HREADY;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = BURST;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    write_d = cmd_write;
                    beat_d  = '0;
                    burst_d = (cmd_len == '0) ? 3'b000 : 3'b001;
                end
            end
            BURST: begin
                if (data_err) begin
                    state_d = ERR;
                end else if (HREADY) begin
                    if (beat_q == len_q) begin
                        state_d = LAST;
                    end else begin
                        addr_d = addr_q + ADDR_W'(BYTES);
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            LAST: begin
                if (data_err) begin
                    state_d = ERR;
                end else if (HREADY && !HRESP) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (HREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            beat_q   <= '0;
            len_q    <= '0;
            write_q  <= 1'b0;
            dp_q     <= 1'b0;
            burst_q  <= 3'b000;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            write_q  <= write_d;
            dp_q     <= dp_d;
            burst_q  <= burst_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule
